// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-word bit map, opcodes and fetch microcode shared by the sequencer.
package ctrl_pkg;
  localparam int CW = 16;
  localparam int I_HLT = 15, I_MI = 14, I_RI = 13, I_RO = 12, I_IO = 11, I_II = 10, I_AI = 9, I_AO = 8;
  localparam int I_EO = 7, I_SU = 6, I_BI = 5, I_OI = 4, I_CE = 3, I_CO = 2, I_J = 1, I_FI = 0;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC = 4'h7, OP_JZ = 4'h8, OP_OUT = 4'he, OP_HLT = 4'hf;
  function automatic logic [CW-1:0] bm(input int i);
    return CW'(1) << i;
  endfunction
  localparam logic [CW-1:0] FETCH_T0 = bm(I_CO) | bm(I_MI);
  localparam logic [CW-1:0] FETCH_T1 = bm(I_RO) | bm(I_II) | bm(I_CE);
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational decode of T-state, opcode and flags into the control word.
module microcode_rom
  import ctrl_pkg::*;
#(
  parameter int OPW = 4,
  parameter int SW  = 3
) (
  input  logic [SW-1:0]  step,
  input  logic [OPW-1:0] opcode,
  input  logic           carry,
  input  logic           zero,
  output logic [CW-1:0]  word
);
  logic [CW-1:0] t2, t3, t4;
  always_comb begin
    t2 = '0;
    t3 = '0;
    t4 = '0;
    case (opcode)
      OP_LDA: begin
        t2 = bm(I_IO) | bm(I_MI);
        t3 = bm(I_RO) | bm(I_AI);
      end
      OP_ADD, OP_SUB: begin
        t2 = bm(I_IO) | bm(I_MI);
        t3 = bm(I_RO) | bm(I_BI);
        t4 = bm(I_EO) | bm(I_AI) | bm(I_FI) | (opcode == OP_SUB ? bm(I_SU) : '0);
      end
      OP_STA: begin
        t2 = bm(I_IO) | bm(I_MI);
        t3 = bm(I_AO) | bm(I_RI);
      end
      OP_LDI: t2 = bm(I_IO) | bm(I_AI);
      OP_JMP: t2 = bm(I_IO) | bm(I_J);
      OP_JC:  t2 = carry ? bm(I_IO) | bm(I_J) : '0;
      OP_JZ:  t2 = zero ? bm(I_IO) | bm(I_J) : '0;
      OP_OUT: t2 = bm(I_AO) | bm(I_OI);
      OP_HLT: t2 = bm(I_HLT);
      default: t2 = '0;
    endcase
    word = step == SW'(0) ? FETCH_T0 :
           step == SW'(1) ? FETCH_T1 :
           step == SW'(2) ? t2 :
           step == SW'(3) ? t3 :
           step == SW'(4) ? t4 : '0;
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state counter with early end and sticky halt, gating microcode onto ctrl.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW       = 4,
  parameter int STEPS     = 5,
  parameter int EARLY_END = 1,
  localparam int SW       = $clog2(STEPS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  input  logic           carry_flag,
  input  logic           zero_flag,
  output logic [CW-1:0]  ctrl,
  output logic [SW-1:0]  step,
  output logic           halted
);
  logic [CW-1:0] word_cur, word_nxt;
  logic [SW-1:0] step_inc, step_nxt;
  logic          halt_hit;
  assign step_inc = step + SW'(1);
  microcode_rom #(.OPW(OPW), .SW(SW)) rom_cur (
    .step(step), .opcode(opcode), .carry(carry_flag), .zero(zero_flag), .word(word_cur)
  );
  // look-ahead copy decides whether the next T-state has any work
  microcode_rom #(.OPW(OPW), .SW(SW)) rom_nxt (
    .step(step_inc), .opcode(opcode), .carry(carry_flag), .zero(zero_flag), .word(word_nxt)
  );
  always_comb begin
    halt_hit = step == SW'(2) && opcode == OPW'(OP_HLT);
    step_nxt = (halt_hit || step == SW'(STEPS - 1) || (EARLY_END != 0 && word_nxt == '0)) ? '0 : step_inc;
    ctrl = !rst_n ? '0 : halted ? bm(I_HLT) : en ? word_cur : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (en && !halted) begin
      step   <= step_nxt;
      halted <= halt_hit;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed plan plus random run of both EARLY_END variants against a table model.
module tb_control_sequencer;
  logic        clk = 1'b0, rst_n, en, carry_flag, zero_flag;
  logic [3:0]  opcode, rop;
  logic [15:0] ctrl, ctrl0;
  logic [2:0]  step, step0;
  logic        halted, halted0;
  int          n_chk = 0, n_pass = 0;
  int          ms[2], mh[2];
  always #5 clk = ~clk;
  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .ctrl(ctrl), .step(step), .halted(halted)
  );
  control_sequencer #(.EARLY_END(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .ctrl(ctrl0), .step(step0), .halted(halted0)
  );
  function automatic logic [15:0] mword(input int s, input logic [3:0] op, input logic c, input logic z);
    logic [15:0] e[3];
    if (s == 0) return 16'h4004;
    if (s == 1) return 16'h1408;
    case (op)
      4'h1: e = '{16'h4800, 16'h1200, 16'h0000};
      4'h2: e = '{16'h4800, 16'h1020, 16'h0281};
      4'h3: e = '{16'h4800, 16'h1020, 16'h02C1};
      4'h4: e = '{16'h4800, 16'h2100, 16'h0000};
      4'h5: e = '{16'h0A00, 16'h0000, 16'h0000};
      4'h6: e = '{16'h0802, 16'h0000, 16'h0000};
      4'h7: e = '{c ? 16'h0802 : 16'h0000, 16'h0000, 16'h0000};
      4'h8: e = '{z ? 16'h0802 : 16'h0000, 16'h0000, 16'h0000};
      4'he: e = '{16'h0110, 16'h0000, 16'h0000};
      4'hf: e = '{16'h8000, 16'h0000, 16'h0000};
      default: e = '{16'h0000, 16'h0000, 16'h0000};
    endcase
    return (s >= 2 && s <= 4) ? e[s-2] : 16'h0000;
  endfunction
  function automatic logic [15:0] mctrl(input int k);
    return !rst_n ? 16'h0 : mh[k] != 0 ? 16'h8000 : !en ? 16'h0 : mword(ms[k], opcode, carry_flag, zero_flag);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic drive(input logic r, input logic e, input logic [3:0] op, input logic c, input logic z);
    rst_n = r; en = e; opcode = op; carry_flag = c; zero_flag = z;
    #1;
    chk("ctrl", 32'(ctrl), 32'(mctrl(1)));
    chk("step", 32'(step), ms[1]);
    chk("halted", 32'(halted), mh[1]);
    chk("ctrl_noearly", 32'(ctrl0), 32'(mctrl(0)));
    chk("step_noearly", 32'(step0), ms[0]);
    chk("halted_noearly", 32'(halted0), mh[0]);
  endtask
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ms[k] = 0;
        mh[k] = 0;
      end else if (en && mh[k] == 0) begin
        if (ms[k] == 2 && opcode == 4'hf) begin
          mh[k] = 1;
          ms[k] = 0;
        end else if (ms[k] == 4 || (k == 1 && mword(ms[k] + 1, opcode, carry_flag, zero_flag) == 16'h0)) ms[k] = 0;
        else ms[k]++;
      end
    end
    @(negedge clk);
  endtask
  task automatic instr(input string tag, input logic [3:0] op, input logic c, input logic z,
                       input int len, input logic [15:0] last);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, 1'b1, op, c, z);
      chk({tag, "_step"}, 32'(step), i);
      if (i == len - 1) chk({tag, "_last"}, 32'(ctrl), 32'(last));
      tick();
    end
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
    @(posedge clk);
    ms = '{0, 0}; mh = '{0, 0};
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    tick();
    instr("lda", 4'h1, 1'b0, 1'b0, 4, 16'h1200);
    instr("sub", 4'h3, 1'b0, 1'b0, 5, 16'h02C1);
    instr("add", 4'h2, 1'b0, 1'b0, 5, 16'h0281);
    instr("jc0", 4'h7, 1'b0, 1'b0, 2, 16'h1408);
    instr("jc1", 4'h7, 1'b1, 1'b0, 3, 16'h0802);
    instr("nop_b", 4'hb, 1'b0, 1'b0, 2, 16'h1408);
    instr("add_pre", 4'h2, 1'b0, 1'b0, 3, 16'h4800);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
      chk("en0_ctrl", 32'(ctrl), 32'h0);
      chk("en0_step", 32'(step), 3);
      tick();
    end
    drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    chk("resume_t3", 32'(ctrl), 32'h1020);
    tick();
    drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    chk("resume_t4", 32'(ctrl), 32'h0281);
    tick();
    instr("sta_pre", 4'h4, 1'b0, 1'b0, 3, 16'h4800);
    drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    chk("sta_rst_ctrl", 32'(ctrl), 32'h0);
    tick();
    instr("hlt", 4'hf, 1'b0, 1'b0, 3, 16'h8000);
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    chk("hlt_sticky", 32'(halted), 1);
    chk("hlt_ctrl", 32'(ctrl), 32'h8000);
    tick();
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    chk("hlt_en0_ctrl", 32'(ctrl), 32'h8000);
    tick();
    drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    chk("hlt_cleared", 32'(halted), 0);
    chk("post_rst_t0", 32'(ctrl), 32'h4004);
    tick();
    rop = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (ms[1] == 0) rop = 4'($urandom);
      drive($urandom_range(63) != 0, $urandom_range(7) != 0, rop, 1'($urandom), 1'($urandom));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode controller for the 8-bit bus CPU.
- Steps a T-state counter through fetch and execute, and decodes opcode, step and flags into the 16-bit control word.
- The control word drives load/output enables of the A, B, IR, MAR, output and flags registers, plus PC, RAM and ALU.
- Sits between the instruction register's upper nibble and every datapath load/enable line.

Parameters:
- OPW, 4, opcode width (IR upper nibble).
- STEPS, 5, T-states per instruction (T0..T4); step counter width is clog2(STEPS).
- EARLY_END, 1, when 1 the sequencer returns to T0 as soon as the next step's microcode word is all-zero.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  run/step enable; 0 freezes sequencing.
- opcode  in  OPW  current instruction opcode from IR.
- carry_flag  in  1  registered carry from flags register.
- zero_flag  in  1  registered zero from flags register.
- ctrl  out  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
- step  out  clog2(STEPS)  current T-state.
- halted  out  1  sticky halt indication.

Behaviour:
- State: step register and halted flag.
- Reset (rst_n=0 at edge): step=0, halted=0. While rst_n is low, ctrl is forced to 0.
- ctrl is combinational from step, opcode and flags, so datapath registers load at the edge ending the step.
- ctrl=0 when en=0. When halted=1, ctrl=0x8000 regardless of en.
- Fetch, identical for all opcodes:
  - T0 = CO|MI = 0x4004.
  - T1 = RO|II|CE = 0x1408.
- Execute, T2/T3/T4:
  - NOP 0x0: none.
  - LDA 0x1: IO|MI 0x4800 / RO|AI 0x1200.
  - ADD 0x2: 0x4800 / RO|BI 0x1020 / EO|AI|FI 0x0281.
  - SUB 0x3: 0x4800 / 0x1020 / EO|SU|AI|FI 0x02C1.
  - STA 0x4: 0x4800 / AO|RI 0x2100.
  - LDI 0x5: IO|AI 0x0A00.
  - JMP 0x6: IO|J 0x0802.
  - JC 0x7: 0x0802 if carry_flag, else 0.
  - JZ 0x8: 0x0802 if zero_flag, else 0.
  - OUT 0xE: AO|OI 0x0110.
  - HLT 0xF: 0x8000.
  - 0x9..0xD: treated as NOP.
- Step advance at each edge with en=1 and halted=0:
  - next = 0 if step == STEPS-1.
  - else next = 0 if EARLY_END=1 and word(step+1, opcode, flags) == 0.
  - else next = step+1.
  - Look-ahead uses current flag inputs.
- Halt: edge with en=1, step=2, opcode=0xF sets halted=1 and step=0. Only rst_n clears halted.
- en=0: step and halted hold.
- Reset mid-instruction: abandons the instruction; next non-reset cycle is T0.
- EARLY_END=0: every instruction takes exactly STEPS cycles with zero words in unused steps.
- Flags change only via FI in T4; the following T0 sees the new flags. No same-instruction hazard.

Decomposition:
- Shared package ctrl_pkg holds:
  - ctrl bit index constants and CW=16;
  - opcode localparams (OP_NOP..OP_HLT);
  - the fetch word constants.
- Sub-module microcode_rom: purely combinational (step, opcode, carry, zero) -> 16-bit word.
  - Instantiated twice: once for the current step and once for the step+1 look-ahead.
- control_sequencer holds the step/halt state, the advance logic and the output gating.

Test Plan:
- Reset then LDA (0x1), en=1 -> ctrl sequence 0x4004, 0x1408, 0x4800, 0x1200, then step=0 next cycle (4 cycles, early end).
- SUB (0x3) with EARLY_END=1 -> 5 cycles, T4 ctrl=0x02C1; ADD T4 ctrl=0x0281.
- JC (0x7), carry=0 -> 0x4004, 0x1408, back to T0 (2 cycles); carry=1 -> T2 ctrl=0x0802, then T0.
- HLT (0xF) -> T2 ctrl=0x8000; next edge halted=1, ctrl stays 0x8000 with en toggling; rst_n=0 one cycle -> halted=0, step=0, ctrl=0x4004 after release.
- en=0 during ADD T3 for 3 cycles -> ctrl=0, step holds 3; en=1 -> resumes with 0x1020 then 0x0281.
- rst_n=0 at STA T3 -> ctrl=0 during reset; step=0 after; undefined opcode 0xB -> 2-cycle NOP; EARLY_END=0 -> 5 cycles.
